// File: rtl/array_walk_pkg.sv
// Shared types and helpers for the array walk accumulator.
package array_walk_pkg;

    localparam int unsigned MAX_SW = 64;

    typedef enum logic {
        SUM = 1'b0,
        INC = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned flat_addr(input int unsigned i, input int unsigned j,
                                              input int unsigned k, input int unsigned d1,
                                              input int unsigned d2);
        return i * d1 * d2 + j * d2 + k;
    endfunction

    // Sign-extends the low w bits of v to MAX_SW bits; callers truncate to SW.
    function automatic logic [MAX_SW-1:0] sext(input logic [MAX_SW-1:0] v, input int unsigned w);
        logic [MAX_SW-1:0] m;
        m = (w >= MAX_SW) ? '1 : ((MAX_SW'(1) << w) - MAX_SW'(1));
        return v[w-1] ? (v | ~m) : (v & m);
    endfunction

endpackage

// File: rtl/array_walk_accum_if.sv
// Control/data bundle for array_walk_accum; brk_val exists only with ARRAY_WALK_BREAK_EN.
interface array_walk_accum_if #(
    parameter int unsigned W  = 16,
    parameter int unsigned SW = 32,
    parameter int unsigned D0 = 2,
    parameter int unsigned D1 = 3,
    parameter int unsigned D2 = 4
) ();
    localparam int unsigned N   = D0 * D1 * D2;
    localparam int unsigned AW  = array_walk_pkg::clog2_min1(N);
    localparam int unsigned IW0 = array_walk_pkg::clog2_min1(D0);
    localparam int unsigned IW1 = array_walk_pkg::clog2_min1(D1);
    localparam int unsigned IW2 = array_walk_pkg::clog2_min1(D2);

    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [W-1:0]   wr_data;
    logic           start;
    logic           mode;
`ifdef ARRAY_WALK_BREAK_EN
    logic [W-1:0]   brk_val;
`endif
    logic           busy;
    logic           done;
    logic           broke;
    logic [SW-1:0]  sum;
    logic [IW0-1:0] idx_i;
    logic [IW1-1:0] idx_j;
    logic [IW2-1:0] idx_k;

    modport master (
        output wr_en, wr_addr, wr_data, start, mode,
`ifdef ARRAY_WALK_BREAK_EN
        output brk_val,
`endif
        input  busy, done, broke, sum, idx_i, idx_j, idx_k
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, mode,
`ifdef ARRAY_WALK_BREAK_EN
        input  brk_val,
`endif
        output busy, done, broke, sum, idx_i, idx_j, idx_k
    );

endinterface

// File: rtl/array_walk_idx.sv
// Nested row-major i/j/k counter (k fastest) with clear, advance and last-element flag.
module array_walk_idx #(
    parameter int unsigned D0  = 2,
    parameter int unsigned D1  = 3,
    parameter int unsigned D2  = 4,
    parameter int unsigned IW0 = 1,
    parameter int unsigned IW1 = 2,
    parameter int unsigned IW2 = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr_i,
    input  logic           adv_i,
    output logic [IW0-1:0] i_o,
    output logic [IW1-1:0] j_o,
    output logic [IW2-1:0] k_o,
    output logic           last_o
);
    localparam logic [IW0-1:0] IMAX = IW0'(D0 - 1);
    localparam logic [IW1-1:0] JMAX = IW1'(D1 - 1);
    localparam logic [IW2-1:0] KMAX = IW2'(D2 - 1);

    logic [IW0-1:0] i_q;
    logic [IW1-1:0] j_q;
    logic [IW2-1:0] k_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
        end else if (clr_i) begin
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
        end else if (adv_i) begin
            if (k_q == KMAX) begin
                k_q <= '0;
                if (j_q == JMAX) begin
                    j_q <= '0;
                    i_q <= (i_q == IMAX) ? '0 : i_q + IW0'(1);
                end else begin
                    j_q <= j_q + IW1'(1);
                end
            end else begin
                k_q <= k_q + IW2'(1);
            end
        end
    end

    assign i_o    = i_q;
    assign j_o    = j_q;
    assign k_o    = k_q;
    assign last_o = (i_q == IMAX) && (j_q == JMAX) && (k_q == KMAX);

endmodule

// File: rtl/array_walk_accum.sv
// Clocked D0xD1xD2 array walker: SUM or INC (write-back) accumulation, one element per cycle.
// Optional early termination on element match when ARRAY_WALK_BREAK_EN is defined.
module array_walk_accum
    import array_walk_pkg::*;
#(
    parameter int unsigned W  = 16,
    parameter int unsigned SW = 32,
    parameter int unsigned D0 = 2,
    parameter int unsigned D1 = 3,
    parameter int unsigned D2 = 4
) (
    input logic              clk,
    input logic              rst,
    array_walk_accum_if.slave bus
);
    localparam int unsigned N   = D0 * D1 * D2;
    localparam int unsigned AW  = clog2_min1(N);
    localparam int unsigned IW0 = clog2_min1(D0);
    localparam int unsigned IW1 = clog2_min1(D1);
    localparam int unsigned IW2 = clog2_min1(D2);

    logic [W-1:0]   mem_q [N];
    state_e         state_q;
    mode_e          mode_q;
    logic [SW-1:0]  acc_q, acc_d;
    logic           busy_q, done_q, broke_q;
    logic [IW0-1:0] idx_i_q, ci;
    logic [IW1-1:0] idx_j_q, cj;
    logic [IW2-1:0] idx_k_q, ck;
    logic           last, hit, clr, adv, wr_ok;
    logic [AW-1:0]  rd_addr;
    logic [W-1:0]   elem, elem_d;

    assign clr   = (state_q == IDLE) && bus.start;
    assign adv   = (state_q == WALK);
    assign wr_ok = bus.wr_en && (32'(bus.wr_addr) < N);

    array_walk_idx #(
        .D0(D0), .D1(D1), .D2(D2), .IW0(IW0), .IW1(IW1), .IW2(IW2)
    ) u_idx (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clr),
        .adv_i (adv),
        .i_o   (ci),
        .j_o   (cj),
        .k_o   (ck),
        .last_o(last)
    );

    always_comb begin
        rd_addr = AW'(flat_addr(32'(ci), 32'(cj), 32'(ck), D1, D2));
        elem    = mem_q[rd_addr];
        elem_d  = (mode_q == INC) ? elem + W'(1) : elem;
        acc_d   = acc_q + SW'(sext(MAX_SW'(elem_d), W));
`ifdef ARRAY_WALK_BREAK_EN
        hit     = (elem == bus.brk_val);
`else
        hit     = 1'b0;
`endif
    end

    // External writes are accepted outside WALK only; during WALK the array belongs to the walker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= SUM;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            broke_q <= 1'b0;
            idx_i_q <= '0;
            idx_j_q <= '0;
            idx_k_q <= '0;
            for (int unsigned n = 0; n < N; n++) mem_q[n] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (wr_ok) mem_q[bus.wr_addr] <= bus.wr_data;
                    if (bus.start) begin
                        state_q <= WALK;
                        mode_q  <= mode_e'(bus.mode);
                        busy_q  <= 1'b1;
                        broke_q <= 1'b0;
                        acc_q   <= '0;
                        idx_i_q <= '0;
                        idx_j_q <= '0;
                        idx_k_q <= '0;
                    end
                end
                WALK: begin
                    acc_q   <= acc_d;
                    idx_i_q <= ci;
                    idx_j_q <= cj;
                    idx_k_q <= ck;
                    if (mode_q == INC) mem_q[rd_addr] <= elem_d;
                    if (last || hit) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        broke_q <= hit;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                    if (wr_ok) mem_q[bus.wr_addr] <= bus.wr_data;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.broke = broke_q;
    assign bus.sum   = acc_q;
    assign bus.idx_i = idx_i_q;
    assign bus.idx_j = idx_j_q;
    assign bus.idx_k = idx_k_q;

endmodule

// File: tb/tb_array_walk_accum.sv
// Directed bench for array_walk_accum: a 2x3x4 default instance and a 1x1x5 instance.
module tb_array_walk_accum;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int unsigned lat, bc, dcnt;

    array_walk_accum_if                          if0 ();
    array_walk_accum_if #(.D0(1), .D1(1), .D2(5)) if5 ();

    array_walk_accum u0 (
        .clk(clk),
        .rst(rst),
        .bus(if0.slave)
    );

    array_walk_accum #(.D0(1), .D1(1), .D2(5)) u5 (
        .clk(clk),
        .rst(rst),
        .bus(if5.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input bit s5, input int unsigned a, input logic [15:0] d);
        if (s5) begin
            if5.wr_en = 1'b1; if5.wr_addr = 3'(a); if5.wr_data = d;
        end else begin
            if0.wr_en = 1'b1; if0.wr_addr = 5'(a); if0.wr_data = d;
        end
        @(posedge clk); #1;
        if5.wr_en = 1'b0;
        if0.wr_en = 1'b0;
    endtask

    // Starts a walk and returns edges from the start edge to done, and busy-high samples seen.
    task automatic walk(input bit s5, input bit m, input int unsigned inj_at,
                        output int unsigned l, output int unsigned b);
        l = 0;
        b = 0;
        if (s5) begin if5.start = 1'b1; if5.mode = m; end
        else    begin if0.start = 1'b1; if0.mode = m; end
        @(posedge clk); #1;
        if5.start = 1'b0; if5.wr_en = 1'b0;
        if0.start = 1'b0; if0.wr_en = 1'b0;
        while (l < 200 && !(s5 ? if5.done : if0.done)) begin
            if (s5 ? if5.busy : if0.busy) b++;
            if (l == inj_at) begin
                if0.start = 1'b1; if0.mode = 1'b1;
                if0.wr_en = 1'b1; if0.wr_addr = 5'd10; if0.wr_data = 16'h1234;
            end
            if (l == inj_at + 1) begin
                if0.start = 1'b0; if0.mode = 1'b0; if0.wr_en = 1'b0;
            end
            @(posedge clk); #1;
            l++;
        end
        if0.start = 1'b0; if0.wr_en = 1'b0;
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        if0.wr_en = 0; if0.wr_addr = '0; if0.wr_data = '0; if0.start = 0; if0.mode = 0;
        if5.wr_en = 0; if5.wr_addr = '0; if5.wr_data = '0; if5.start = 0; if5.mode = 0;
`ifdef ARRAY_WALK_BREAK_EN
        if0.brk_val = 16'h7777;
        if5.brk_val = 16'h7777;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_busy",  if0.busy,  0);
        chk("rst_done",  if0.done,  0);
        chk("rst_broke", if0.broke, 0);
        chk("rst_sum",   if0.sum,   0);
        chk("rst_idx",   {if0.idx_i, if0.idx_j, if0.idx_k}, 0);

        // 1 at addresses 11 and 23, full SUM walk
        wr(0, 11, 16'h0001);
        wr(0, 23, 16'h0001);
        walk(0, 0, 999, lat, bc);
        chk("t1_latency", lat, 24);
        chk("t1_busy_cycles", bc, 24);
        chk("t1_sum", if0.sum, 2);
        chk("t1_idx_i", if0.idx_i, 1);
        chk("t1_idx_j", if0.idx_j, 2);
        chk("t1_idx_k", if0.idx_k, 3);
        chk("t1_broke", if0.broke, 0);
        @(posedge clk); #1;
        chk("t1_done_pulse", if0.done, 0);
        chk("t1_idle_busy", if0.busy, 0);
        chk("t1_sum_hold", if0.sum, 2);

        // Sign extension: 0x8000 + 0x0001
        wr(0, 11, 16'h0000);
        wr(0, 23, 16'h0000);
        wr(0, 0, 16'h8000);
        wr(0, 5, 16'h0001);
        walk(0, 0, 999, lat, bc);
        chk("t2_sum", if0.sum, 32'hFFFF8001);
        @(posedge clk); #1;

        // start + wr_en (addr 10) injected mid-walk are ignored
        walk(0, 0, 3, lat, bc);
        chk("t3_latency", lat, 24);
        chk("t3_sum", if0.sum, 32'hFFFF8001);
        @(posedge clk); #1;
        chk("t3_no_restart", if0.busy, 0);
        walk(0, 0, 999, lat, bc);
        chk("t3_array_kept", if0.sum, 32'hFFFF8001);
        @(posedge clk); #1;

        // 1x1x5 instance: INC on {1,2,3,4,5}
        for (int unsigned a = 0; a < 5; a++) wr(1, a, 16'(a + 1));
        walk(1, 1, 999, lat, bc);
        chk("t4_latency", lat, 5);
        chk("t4_inc_sum", if5.sum, 20);
        chk("t4_idx", {if5.idx_i, if5.idx_j, if5.idx_k}, {1'b0, 1'b0, 3'd4});
        @(posedge clk); #1;
        walk(1, 0, 999, lat, bc);
        chk("t4_readback_sum", if5.sum, 20);
        @(posedge clk); #1;

        // 0xFFFF wraps to 0 under INC: {FFFF,3,4,5,6} -> {0,4,5,6,7}
        wr(1, 0, 16'hFFFF);
        walk(1, 1, 999, lat, bc);
        chk("t5_wrap_inc_sum", if5.sum, 22);
        @(posedge clk); #1;
        walk(1, 0, 999, lat, bc);
        chk("t5_wrap_readback", if5.sum, 22);
        @(posedge clk); #1;

        // Write and start in the same idle cycle: walk sees 100 at address 4
        if5.wr_en = 1'b1; if5.wr_addr = 3'd4; if5.wr_data = 16'd100;
        walk(1, 0, 999, lat, bc);
        chk("t6_same_cycle_sum", if5.sum, 115);
        @(posedge clk); #1;

        // Reset mid-walk on the default instance
        if0.start = 1'b1; if0.mode = 1'b0;
        @(posedge clk); #1;
        if0.start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("t7_busy_before_rst", if0.busy, 1);
        rst = 1'b1;
        #1;
        chk("t7_rst_busy", if0.busy, 0);
        chk("t7_rst_sum", if0.sum, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        dcnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (if0.done) dcnt++;
        end
        chk("t7_no_done", dcnt, 0);

`ifdef ARRAY_WALK_BREAK_EN
        wr(0, 11, 16'h0001);
        if0.brk_val = 16'h0001;
        walk(0, 0, 999, lat, bc);
        chk("t8_brk_latency", lat, 12);
        chk("t8_brk_broke", if0.broke, 1);
        chk("t8_brk_idx_i", if0.idx_i, 0);
        chk("t8_brk_idx_j", if0.idx_j, 2);
        chk("t8_brk_idx_k", if0.idx_k, 3);
        chk("t8_brk_sum", if0.sum, 1);
        @(posedge clk); #1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
